// File: rtl/destuff_ctrl_if.sv
// Bit-level link between the sampling front end and the bit destuffer.
interface destuff_ctrl_if #(
  parameter int unsigned CNT_W = 3
);
  logic             SP;
  logic             RX;
  logic             SOF_SYNC;
  logic             F_STF;
  logic             F_FIX;
  logic             sp_decision;
  logic             data_bit;
  logic             stuff_bit;
  logic             stuff_err;
  logic [CNT_W-1:0] stuff_cnt;

  // Sampler side: drives sampled bits and mode flags, observes the decisions.
  modport master (
    output SP, RX, SOF_SYNC, F_STF, F_FIX,
    input  sp_decision, data_bit, stuff_bit, stuff_err, stuff_cnt
  );

  // Destuffer side.
  modport slave (
    input  SP, RX, SOF_SYNC, F_STF, F_FIX,
    output sp_decision, data_bit, stuff_bit, stuff_err, stuff_cnt
  );
endinterface

// File: rtl/destuff_ctrl.sv
// Bit destuffer: classifies every sampled bit as data, removed stuff bit or
// stuff error, in dynamic (run-length) or fixed-interval stuffing mode.
module destuff_ctrl #(
  parameter int unsigned STUFF_LEN = 5,
  parameter int unsigned FIXED_LEN = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  destuff_ctrl_if.slave bus
);

  localparam int unsigned RUN_W = $clog2(STUFF_LEN + 1);
  localparam int unsigned FIX_W = $clog2(FIXED_LEN + 1);

  logic             prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [FIX_W-1:0] fix_cnt_q, fix_cnt_d;
  logic             expect_q, expect_d;
  logic             fix_mode_q, fix_mode_d;
  logic             dec_q, dec_d;
  logic             data_q, data_d;
  logic             stb_q, stb_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and registered outputs; reset drops any pending stuff expectation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= 1'b1;
      run_q      <= RUN_W'(1);
      fix_cnt_q  <= '0;
      expect_q   <= 1'b0;
      fix_mode_q <= 1'b0;
      dec_q      <= 1'b0;
      data_q     <= 1'b1;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      prev_q     <= prev_d;
      run_q      <= run_d;
      fix_cnt_q  <= fix_cnt_d;
      expect_q   <= expect_d;
      fix_mode_q <= fix_mode_d;
      dec_q      <= dec_d;
      data_q     <= data_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Per-sample classification, priority SOF > stuffing off > fixed > dynamic.
  always_comb begin
    logic [RUN_W-1:0] run_inc;
    prev_d     = prev_q;
    run_d      = run_q;
    fix_cnt_d  = fix_cnt_q;
    expect_d   = expect_q;
    fix_mode_d = fix_mode_q;
    dec_d      = 1'b0;
    data_d     = data_q;
    stb_d      = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    run_inc    = (bus.RX == prev_q) ? run_q + RUN_W'(1) : RUN_W'(1);

    if (bus.SP) begin
      data_d     = bus.RX;
      prev_d     = bus.RX;
      fix_mode_d = bus.F_FIX;
      if (bus.SOF_SYNC) begin
        dec_d      = 1'b1;
        run_d      = RUN_W'(1);
        cnt_d      = '0;
        fix_cnt_d  = '0;
        expect_d   = 1'b0;
        fix_mode_d = 1'b0;
      end else if (bus.F_STF) begin
        dec_d    = 1'b1;
        run_d    = RUN_W'(1);
        expect_d = 1'b0;
      end else if (bus.F_FIX) begin
        // Run tracking is parked so dynamic mode restarts cleanly on exit.
        run_d    = RUN_W'(1);
        expect_d = 1'b0;
        if (!fix_mode_q || (fix_cnt_q == FIX_W'(FIXED_LEN))) begin
          stb_d     = (bus.RX != prev_q);
          err_d     = (bus.RX == prev_q);
          fix_cnt_d = '0;
        end else begin
          dec_d     = 1'b1;
          fix_cnt_d = fix_cnt_q + FIX_W'(1);
        end
      end else if (!expect_q) begin
        dec_d    = 1'b1;
        run_d    = run_inc;
        expect_d = (run_inc == RUN_W'(STUFF_LEN));
      end else begin
        run_d    = RUN_W'(1);
        expect_d = 1'b0;
        if (bus.RX != prev_q) begin
          stb_d = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  assign bus.sp_decision = dec_q;
  assign bus.data_bit    = data_q;
  assign bus.stuff_bit   = stb_q;
  assign bus.stuff_err   = err_q;
  assign bus.stuff_cnt   = cnt_q;

endmodule

// File: tb/tb_destuff_ctrl.sv
// Directed bench for destuff_ctrl with hand-computed expectations.
module tb_destuff_ctrl;

  localparam int unsigned CNT_W = 3;
  localparam logic [2:0] DEC  = 3'b100;
  localparam logic [2:0] STB  = 3'b010;
  localparam logic [2:0] ERR  = 3'b001;
  localparam logic [2:0] NONE = 3'b000;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic p;

  always #5 clk = ~clk;

  destuff_ctrl_if #(.CNT_W(CNT_W)) bus ();

  destuff_ctrl #(.STUFF_LEN(5), .FIXED_LEN(4), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] pulses();
    return {bus.sp_decision, bus.stuff_bit, bus.stuff_err};
  endfunction

  // One SP cycle, check the registered result, then an idle cycle with no pulse.
  task automatic sp(input logic sof, input logic stf, input logic fix, input logic rx,
                    input logic [2:0] exp_p, input int exp_cnt, input string tag);
    @(negedge clk);
    bus.SP = 1'b1; bus.RX = rx; bus.SOF_SYNC = sof; bus.F_STF = stf; bus.F_FIX = fix;
    @(negedge clk);
    bus.SP = 1'b0; bus.SOF_SYNC = 1'b0;
    check({tag, ".pulse"}, 32'(pulses()), 32'(exp_p));
    check({tag, ".data"},  32'(bus.data_bit), 32'(rx));
    check({tag, ".cnt"},   32'(bus.stuff_cnt), 32'(exp_cnt));
    @(negedge clk);
    check({tag, ".idle"},  32'(pulses()), 32'(NONE));
  endtask

  initial begin
    reset_n = 1'b0;
    bus.SP = 1'b0; bus.RX = 1'b1; bus.SOF_SYNC = 1'b0; bus.F_STF = 1'b0; bus.F_FIX = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.pulse", 32'(pulses()), 32'(NONE));
    check("rst.data",  32'(bus.data_bit), 32'd1);
    check("rst.cnt",   32'(bus.stuff_cnt), 32'd0);
    reset_n = 1'b1;

    // Five equal bits then a stuff bit.
    sp(1, 0, 0, 0, DEC, 0, "s34.sof");
    for (int i = 0; i < 4; i++) sp(0, 0, 0, 0, DEC, 0, "s34.d");
    sp(0, 0, 0, 1, STB, 1, "s34.stuff");
    sp(0, 0, 0, 1, DEC, 1, "s34.after");

    // Sixth equal bit is a stuff error; run restarts afterwards.
    sp(1, 0, 0, 0, DEC, 0, "s35.sof");
    for (int i = 0; i < 4; i++) sp(0, 0, 0, 0, DEC, 0, "s35.d");
    sp(0, 0, 0, 0, ERR, 0, "s35.err");
    sp(0, 0, 0, 1, DEC, 0, "s35.restart");
    for (int i = 0; i < 4; i++) sp(0, 0, 0, 1, DEC, 0, "s35.run");
    sp(0, 0, 0, 0, STB, 1, "s35.stuff");

    // Nine stuff bits: counter wraps through zero.
    sp(1, 0, 0, 0, DEC, 0, "s36.sof");
    p = 1'b0;
    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < 4; j++) sp(0, 0, 0, p, DEC, k % 8, "s36.d");
      sp(0, 0, 0, ~p, STB, (k + 1) % 8, "s36.stuff");
      p = ~p;
    end

    // Fixed stuffing: entry stuff, four data bits, bad fixed stuff, then exit.
    sp(1, 0, 0, 0, DEC, 0, "s37.sof");
    for (int i = 0; i < 4; i++) sp(0, 0, 0, 0, DEC, 0, "s37.d");
    sp(0, 0, 0, 1, STB, 1, "s37.dyn_stuff");
    sp(0, 0, 1, 0, STB, 1, "s37.entry");
    for (int i = 0; i < 4; i++) sp(0, 0, 1, 1, DEC, 1, "s37.fd");
    sp(0, 0, 1, 1, ERR, 1, "s37.fix_err");
    sp(0, 0, 1, 0, DEC, 1, "s37.fd2");
    for (int i = 0; i < 4; i++) sp(0, 0, 0, 0, DEC, 1, "s37.exit");
    sp(0, 0, 0, 1, STB, 2, "s37.dyn_again");
    sp(0, 0, 0, 1, DEC, 2, "s37.tail");

    // Stuffing disabled: long runs pass as data, dynamic resumes with run=1.
    sp(1, 0, 0, 0, DEC, 0, "s38.sof");
    for (int i = 0; i < 3; i++) sp(0, 0, 0, 0, DEC, 0, "s38.d");
    for (int i = 0; i < 8; i++) sp(0, 1, 0, 1, DEC, 0, "s38.stf");
    for (int i = 0; i < 4; i++) sp(0, 0, 0, 1, DEC, 0, "s38.run");
    sp(0, 0, 0, 1, ERR, 0, "s38.err");

    // Reset while a stuff bit is expected.
    sp(1, 0, 0, 0, DEC, 0, "s39.sof");
    for (int i = 0; i < 4; i++) sp(0, 0, 0, 0, DEC, 0, "s39.d");
    sp(0, 0, 0, 1, STB, 1, "s39.stuff");
    for (int i = 0; i < 5; i++) sp(0, 0, 0, 0, DEC, 1, "s39.run");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("s39.rst.pulse", 32'(pulses()), 32'(NONE));
    check("s39.rst.data",  32'(bus.data_bit), 32'd1);
    check("s39.rst.cnt",   32'(bus.stuff_cnt), 32'd0);
    @(negedge clk);
    bus.SP = 1'b1; bus.RX = 1'b0; bus.SOF_SYNC = 1'b1;
    @(negedge clk);
    bus.SP = 1'b0; bus.SOF_SYNC = 1'b0;
    check("s39.rst_sp.pulse", 32'(pulses()), 32'(NONE));
    check("s39.rst_sp.data",  32'(bus.data_bit), 32'd1);
    reset_n = 1'b1;
    sp(0, 0, 0, 1, DEC, 0, "s39.first");
    sp(1, 0, 0, 1, DEC, 0, "s39.sof");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/destuff_ctrl.md
DESTUFF_CTRL -- requirements
Module: destuff_ctrl

Interface
REQ-001 Parameter STUFF_LEN, default 5: equal-bit run length that forces a dynamic stuff bit.
REQ-002 Parameter FIXED_LEN, default 4: data bits between fixed stuff bits in fixed mode.
REQ-003 Parameter CNT_W, default 3: width of stuff_cnt.
REQ-004 clk  input  1  single block clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 SP  input  1  sample-point strobe, one clk cycle wide; RX is sampled only when SP=1.
REQ-007 RX  input  1  bus bit, synchronous to clk.
REQ-008 SOF_SYNC  input  1  current sampled bit is start-of-frame.
REQ-009 F_STF  input  1  stuffing disabled (no removal, no checks).
REQ-010 F_FIX  input  1  fixed-stuff mode select.
REQ-011 sp_decision  output  1  one-cycle pulse: sampled bit is a data bit.
REQ-012 data_bit  output  1  value of the bit qualified by sp_decision.
REQ-013 stuff_bit  output  1  one-cycle pulse: sampled bit was a valid stuff bit and was removed.
REQ-014 stuff_err  output  1  one-cycle pulse: stuff rule violated.
REQ-015 stuff_cnt  output  CNT_W  dynamic stuff bits removed since SOF, modulo 2^CNT_W.

Function
REQ-016 All outputs SHALL be registered and valid the clk cycle after the SP cycle (latency 1); pulses SHALL last exactly one cycle.
REQ-017 Per SP exactly one of sp_decision, stuff_bit, stuff_err SHALL pulse; none SHALL pulse without SP.
REQ-018 Internal state: prev (last sampled bit), run (1..STUFF_LEN), fix_cnt (0..FIXED_LEN), expect_stuff flag, fix_mode_d (F_FIX at previous SP).
REQ-019 Priority at SP, highest first: SOF_SYNC, F_STF, F_FIX, dynamic.
REQ-020 SOF_SYNC=1: data bit; run=1, prev=RX, stuff_cnt=0, fix_cnt=0, expect_stuff=0, fix_mode_d=0.
REQ-021 F_STF=1: data bit; run=1, prev=RX, expect_stuff=0; stuff_cnt held.
REQ-022 Dynamic, expect_stuff=0: data bit; run=run+1 if RX==prev else 1; prev=RX; expect_stuff=1 when new run==STUFF_LEN.
REQ-023 Dynamic, expect_stuff=1, RX!=prev: stuff_bit; stuff_cnt+1 (wraps); run=1; prev=RX; expect_stuff=0.
REQ-024 Dynamic, expect_stuff=1, RX==prev: stuff_err; run=1; prev=RX; expect_stuff=0; stuff_cnt held.
REQ-025 Fixed mode entry (F_FIX=1, fix_mode_d=0): bit is a fixed stuff bit; fix_cnt=0.
REQ-026 Fixed mode, fix_cnt<FIXED_LEN (not entry): data bit; fix_cnt+1; prev=RX; no run check.
REQ-027 Fixed stuff bit (entry, or fix_cnt==FIXED_LEN): RX!=prev -> stuff_bit, RX==prev -> stuff_err; fix_cnt=0; prev=RX; stuff_cnt not incremented.
REQ-028 Leaving fixed mode (F_FIX=0 at SP): resume dynamic with run=1, expect_stuff=0.
REQ-029 fix_mode_d SHALL update only on SP.
REQ-030 data_bit SHALL equal sampled RX for every SP outcome.

Reset
REQ-031 reset_n=0 SHALL immediately force sp_decision=0, data_bit=1, stuff_bit=0, stuff_err=0, stuff_cnt=0, prev=1, run=1, fix_cnt=0, expect_stuff=0, fix_mode_d=0.
REQ-032 Reset asserted mid-frame SHALL discard expect_stuff and counts; SP during reset SHALL be ignored.
REQ-033 After release, first SP SHALL be processed per REQ-019 with reset state.

Verification
REQ-034 SOF 0, then 0,0,0,0 (defaults) -> 5 sp_decision; next RX=1 -> stuff_bit, stuff_cnt=1; next 1 -> sp_decision.
REQ-035 SOF 0, four 0s, then 0 -> stuff_err pulse, no sp_decision; following 1 -> sp_decision, run restarts.
REQ-036 Nine stuff bits after SOF with CNT_W=3 -> stuff_cnt counts 1..7,0,1 (wrap).
REQ-037 F_FIX rises, RX opposite prev -> stuff_bit; 4 data bits -> 4 sp_decision; 5th bit equal prev -> stuff_err; stuff_cnt unchanged.
REQ-038 F_STF=1, eight 1s -> eight sp_decision, no stuff_bit/stuff_err.
REQ-039 reset_n low between SP pulses while expect_stuff=1 -> outputs per REQ-031 at once; next SP RX=1 after SOF -> sp_decision.
